// File: rtl/pwm_spi_write_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_spi_write_sequencer
//
// SPI configuration front-end and write scheduler for the 8-channel 3-bit PWM
// driver. 8-bit command frames arrive over a 3-wire SPI link (mode 0, MSB
// first). Each frame is parity-checked and queued in a small FIFO. It is then
// replayed as a single write (unicast) or as eight writes to channels 0..7
// (broadcast) on the driver's set/addr/level port. Writes are issued only
// while commit_ok is high.
//
// Frame: [7] B (broadcast), [6:4] addr, [3:1] level, [0] even parity.
//
// Ports:
//   clk, rst_n     system clock; asynchronous active-low reset
//   spi_sclk       SPI clock (asynchronous, <= clk/4)
//   spi_cs_n       SPI chip select, active low (asynchronous)
//   spi_mosi       SPI data, MSB first (asynchronous)
//   commit_ok      write permission
//   pwm_set        one-cycle write strobe to the PWM driver
//   pwm_addr       channel address of the write (held between writes)
//   pwm_level      level of the write (held between writes)
//   busy           FIFO non-empty or sequencer not idle
//   parity_err     sticky: a frame failed parity
//   overflow_err   sticky: a good frame was dropped on a full FIFO
// -----------------------------------------------------------------------------
module pwm_spi_write_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       commit_ok,
    output logic       pwm_set,
    output logic [2:0] pwm_addr,
    output logic [2:0] pwm_level,
    output logic       busy,
    output logic       parity_err,
    output logic       overflow_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_BCAST
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (2 flops each) and sclk rising-edge detect
    // ------------------------------------------------------------------
    logic sclk_s1, sclk_s2, sclk_prev;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic sclk_rise;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            cs_s1     <= 1'b1;   // deselected while in reset
            cs_s2     <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            sclk_s1   <= spi_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            cs_s1     <= spi_cs_n;
            cs_s2     <= cs_s1;
            mosi_s1   <= spi_mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_prev;

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       frame_done;   // shift_reg holds a complete frame this cycle

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= 8'd0;
            bit_cnt    <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cs_s2) begin
                // Deselect discards any partial frame silently.
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[6:0], mosi_s2};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    frame_done <= 1'b1;
                end
            end
        end
    end

    // The next sclk rise is at least 4 clk away, so shift_reg is stable
    // during the frame_done cycle and can be pushed directly.
    logic frame_ok;
    assign frame_ok = ~^shift_reg;

    // ------------------------------------------------------------------
    // Frame FIFO: stores {B, addr, level}
    // ------------------------------------------------------------------
    logic [6:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;
    logic             push_req, push, pop;
    logic [6:0]       head;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = frame_done & frame_ok;
    // A full FIFO still accepts the frame when the head leaves this cycle.
    assign push       = push_req & (~fifo_full | pop);
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are valid, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg[7:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            parity_err   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (frame_done && !frame_ok) parity_err <= 1'b1;
            if (push_req && fifo_full && !pop) overflow_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write sequencer FSM (outputs are registered from *_next)
    // ------------------------------------------------------------------
    state_t     state, state_next;
    logic [2:0] ch_cnt, ch_next;
    logic [2:0] bcast_level, bcast_level_next;
    logic       set_next;
    logic [2:0] addr_next, level_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ch_cnt      <= 3'd0;
            bcast_level <= 3'd0;
            pwm_set     <= 1'b0;
            pwm_addr    <= 3'd0;
            pwm_level   <= 3'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            ch_cnt      <= ch_next;
            bcast_level <= bcast_level_next;
            pwm_set     <= set_next;
            pwm_addr    <= addr_next;
            pwm_level   <= level_next;
            busy        <= ~fifo_empty | (state != ST_IDLE);
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        ch_next          = ch_cnt;
        bcast_level_next = bcast_level;
        pop              = 1'b0;
        set_next         = 1'b0;
        addr_next        = pwm_addr;    // hold last written values
        level_next       = pwm_level;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && commit_ok) begin
                    pop = 1'b1;
                    if (head[6]) begin
                        state_next       = ST_BCAST;
                        ch_next          = 3'd0;
                        bcast_level_next = head[2:0];
                    end else begin
                        // Strobe is registered here, so WRITE is the cycle
                        // in which pwm_set is high.
                        state_next = ST_WRITE;
                        set_next   = 1'b1;
                        addr_next  = head[5:3];
                        level_next = head[2:0];
                    end
                end
            end

            ST_WRITE: begin
                state_next = ST_IDLE;
            end

            ST_BCAST: begin
                // Without permission the counter holds, so the broadcast
                // resumes at the same channel.
                if (commit_ok) begin
                    set_next   = 1'b1;
                    addr_next  = ch_cnt;
                    level_next = bcast_level;
                    ch_next    = ch_cnt + 3'd1;
                    if (ch_cnt == 3'd7) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_spi_write_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_spi_write_sequencer
//
// Directed bench for pwm_spi_write_sequencer. Each SPI frame that should
// produce writes pushes the expected {addr, level} pairs to a scoreboard
// queue. A monitor pops and compares an entry for every pwm_set pulse.
// -----------------------------------------------------------------------------
module tb_pwm_spi_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       commit_ok;
    logic       pwm_set;
    logic [2:0] pwm_addr;
    logic [2:0] pwm_level;
    logic       busy;
    logic       parity_err;
    logic       overflow_err;

    pwm_spi_write_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .commit_ok    (commit_ok),
        .pwm_set      (pwm_set),
        .pwm_addr     (pwm_addr),
        .pwm_level    (pwm_level),
        .busy         (busy),
        .parity_err   (parity_err),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] addr;
        logic [2:0] level;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks      = 0;
    int  n_pass        = 0;
    int  cyc           = 0;
    int  writes_total  = 0;
    int  last_set_cyc  = 0;
    int  last_rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n === 1'b1 && pwm_set === 1'b1) begin
            writes_total++;
            last_set_cyc = cyc;
            check("sb_entry_available", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", pwm_addr, e.addr);
                check("wr_level", pwm_level, e.level);
            end
        end
    end

    initial begin : watchdog
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [2:0] addr, input logic [2:0] level);
        wr_t e;
        e.addr  = addr;
        e.level = level;
        exp_q.push_back(e);
    endtask

    task automatic push_bcast(input logic [2:0] level);
        for (int ch = 0; ch < 8; ch++) push_exp(3'(ch), level);
    endtask

    // Mode 0, MSB first, sclk period 6 clk.
    task automatic send_bits(input logic [7:0] data, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = data[i];
            tick(3);
            spi_sclk      = 1'b1;
            last_rise_cyc = cyc;
            tick(3);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(2);
        spi_cs_n = 1'b1;
        tick(4);
    endtask

    task automatic send_frame(input logic [7:0] data);
        cs_low();
        send_bits(data, 8);
        cs_high();
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin : stimulus
        logic [7:0] frames [5];
        int         run;
        int         seen;
        int         base;
        bit         got;

        rst_n     = 1'b0;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        commit_ok = 1'b0;

        // ---- reset state ----
        tick(2);
        check("rst_pwm_set", pwm_set, 1'b0);
        check("rst_pwm_addr", pwm_addr, 3'd0);
        check("rst_pwm_level", pwm_level, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_overflow_err", overflow_err, 1'b0);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_busy", busy, 1'b0);

        // ---- unicast 0x56: addr 5, level 3, set at edge k+4 ----
        commit_ok = 1'b1;
        push_exp(3'd5, 3'd3);
        send_frame(8'h56);
        drain("uni_drain");
        // Rise driven after posedge c; sync1 captures at c+1 (k); set from k+4.
        check("uni_latency", last_set_cyc - last_rise_cyc, 5);
        tick(4);
        check("uni_busy_after", busy, 1'b0);
        check("uni_parity_err", parity_err, 1'b0);
        check("uni_overflow_err", overflow_err, 1'b0);

        // ---- broadcast 0x8D: level 6 to channels 0..7, 8 consecutive ----
        push_bcast(3'd6);
        cs_low();
        send_bits(8'h8D, 8);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pwm_set) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        check("bcast_start", got, 1'b1);
        run = 0;
        for (int i = 0; i < 8; i++) begin
            if (pwm_set) run++;
            tick(1);
        end
        check("bcast_run_len", run, 8);
        check("bcast_end", pwm_set, 1'b0);
        cs_high();
        drain("bcast_drain");

        // ---- broadcast with a 3-cycle commit_ok pause ----
        base = writes_total;
        push_bcast(3'd6);
        cs_low();
        send_bits(8'h8D, 8);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (pwm_set) seen++;
            if (seen == 2) break;
            tick(1);
        end
        check("pause_two_writes", seen, 2);
        commit_ok = 1'b0;
        tick(1);
        check("pause_no_set", pwm_set, 1'b0);
        tick(2);
        check("pause_no_set_late", pwm_set, 1'b0);
        commit_ok = 1'b1;
        cs_high();
        drain("pause_drain");
        tick(4);
        check("pause_write_count", writes_total - base, 8);

        // ---- parity error 0x57, then 0x56 still written ----
        base = writes_total;
        send_frame(8'h57);
        tick(10);
        check("par_err_set", parity_err, 1'b1);
        check("par_no_write", writes_total - base, 0);
        check("par_no_overflow", overflow_err, 1'b0);
        push_exp(3'd5, 3'd3);
        send_frame(8'h56);
        drain("par_follow_drain");
        check("par_err_sticky", parity_err, 1'b1);

        // ---- overflow: 5 good frames with commit_ok low ----
        // Addr 5,4,3,2,1, level 3, each with even parity.
        frames[0] = 8'h56;
        frames[1] = 8'h47;
        frames[2] = 8'h36;
        frames[3] = 8'h27;
        frames[4] = 8'h17;
        commit_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(3'(5 - i), 3'd3);
            send_frame(frames[i]);
            tick(4);
            if (i == 3) check("ovf_not_yet", overflow_err, 1'b0);
        end
        check("ovf_set", overflow_err, 1'b1);
        check("ovf_busy_waiting", busy, 1'b1);
        check("ovf_no_write_yet", pwm_set, 1'b0);
        commit_ok = 1'b1;
        drain("ovf_drain");
        tick(4);
        check("ovf_busy_after", busy, 1'b0);
        check("ovf_parity_still", parity_err, 1'b1);

        // ---- partial frame discard, then two frames in one cs window ----
        do_reset();
        check("rst2_parity_err", parity_err, 1'b0);
        check("rst2_overflow_err", overflow_err, 1'b0);
        cs_low();
        send_bits(8'hA5, 5);
        cs_high();
        push_exp(3'd5, 3'd3);
        send_frame(8'h56);
        drain("partial_drain");
        tick(4);
        check("partial_parity_err", parity_err, 1'b0);
        check("partial_overflow_err", overflow_err, 1'b0);
        base = writes_total;
        push_exp(3'd5, 3'd3);
        push_exp(3'd3, 3'd3);
        cs_low();
        send_bits(8'h56, 8);
        send_bits(8'h36, 8);
        cs_high();
        drain("two_frame_drain");
        tick(4);
        check("two_frame_count", writes_total - base, 2);

        // ---- reset in the middle of a broadcast ----
        push_bcast(3'd6);
        cs_low();
        send_bits(8'h8D, 8);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (pwm_set) seen++;
            if (seen == 3) break;
            tick(1);
        end
        check("midrst_three_writes", seen, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_set", pwm_set, 1'b0);
        check("midrst_addr", pwm_addr, 3'd0);
        check("midrst_level", pwm_level, 3'd0);
        check("midrst_busy", busy, 1'b0);
        exp_q.delete();
        base = writes_total;
        cs_high();
        rst_n = 1'b1;
        tick(40);
        check("midrst_no_writes", writes_total - base, 0);
        check("midrst_busy_after", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
